// File: rtl/pulse_monitor.sv
// pulse_monitor
//   Measures one pulse per start trigger: the delay in clk cycles from the
//   start rise to the pulse_in rise, and the number of cycles pulse_in stays
//   high. The result is held with a valid/ready handshake until consumed.
//
// Parameters
//   SYNC_STAGES    : synchronizer depth for pulse_in (2..4); start is delayed
//                    by the same amount so both edges stay aligned
//   CNT_W          : width of the delay and width counters (saturating)
//   TIMEOUT_CYCLES : cycles waited for each pulse edge before aborting
//
// Ports
//   clk        : clock, all state on the rising edge
//   reset      : asynchronous active-low reset
//   start      : synchronous measurement trigger (rising edge)
//   pulse_in   : asynchronous pulse under measurement
//   meas_valid : result held and available
//   meas_ready : consumer accepts the result on meas_valid & meas_ready
//   delay_out  : cycles from start rise to pulse_in rise
//   width_out  : cycles pulse_in was sampled high
//   timeout    : measurement aborted, an edge did not arrive in time
//   saturated  : a counter clipped at all-ones
//   busy       : FSM is outside IDLE
module pulse_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pulse_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] delay_out,
  output logic [CNT_W-1:0] width_out,
  output logic             timeout,
  output logic             saturated,
  output logic             busy
);

  // The edge timer is sized from TIMEOUT_CYCLES rather than CNT_W so that a
  // narrow, already saturated counter can never prevent the abort.
  localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE_HIGH,
    REPORT
  } state_t;

  // Returns {clipped, next_value}; holds at all-ones instead of wrapping.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return {1'b1, v};
    end
    return {1'b0, v + CNT_W'(1)};
  endfunction

  logic [SYNC_STAGES-1:0] pulse_p;
  logic [SYNC_STAGES-1:0] start_p;
  logic                   pulse_prev;
  logic                   start_prev;
  logic                   pulse_s;
  logic                   pulse_rise;
  logic                   start_rise;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] delay_q,   delay_d;
  logic [CNT_W-1:0] width_q,   width_d;
  logic [TMR_W-1:0] tmr_q,     tmr_d;
  logic             timeout_q, timeout_d;
  logic             sat_q,     sat_d;
  logic [TMR_W-1:0] tmr_inc;
  logic [CNT_W:0]   delay_inc;
  logic [CNT_W:0]   width_inc;

  // Stage: synchronizer for pulse_in and matching delay line for start,
  // followed by one register of history for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_p    <= '0;
      start_p    <= '0;
      pulse_prev <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      pulse_p    <= {pulse_p[SYNC_STAGES-2:0], pulse_in};
      start_p    <= {start_p[SYNC_STAGES-2:0], start};
      pulse_prev <= pulse_p[SYNC_STAGES-1];
      start_prev <= start_p[SYNC_STAGES-1];
    end
  end

  assign pulse_s    = pulse_p[SYNC_STAGES-1];
  assign pulse_rise = pulse_s & ~pulse_prev;
  assign start_rise = start_p[SYNC_STAGES-1] & ~start_prev;

  // Stage: measurement FSM next-state and counter logic.
  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    width_d   = width_q;
    tmr_d     = tmr_q;
    timeout_d = timeout_q;
    sat_d     = sat_q;
    tmr_inc   = tmr_q + TMR_W'(1);
    delay_inc = sat_inc(delay_q);
    width_inc = sat_inc(width_q);

    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d   = WAIT_RISE;
          delay_d   = '0;
          width_d   = '0;
          tmr_d     = '0;
          timeout_d = 1'b0;
          sat_d     = 1'b0;
        end
      end

      WAIT_RISE: begin
        // The rise cycle itself is counted, so a pulse first sampled D
        // edges after start reports exactly D.
        delay_d = delay_inc[CNT_W-1:0];
        sat_d   = sat_q | delay_inc[CNT_W];
        if (pulse_rise) begin
          // The rise cycle is also the first high sample of the width.
          state_d = MEASURE_HIGH;
          width_d = CNT_W'(1);
          tmr_d   = TMR_W'(1);
        end else if (tmr_inc == TMR_LIMIT) begin
          state_d   = REPORT;
          timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_inc;
        end
      end

      MEASURE_HIGH: begin
        if (pulse_s) begin
          width_d = width_inc[CNT_W-1:0];
          sat_d   = sat_q | width_inc[CNT_W];
          tmr_d   = tmr_inc;
          if (tmr_inc == TMR_LIMIT) begin
            state_d   = REPORT;
            timeout_d = 1'b1;
          end
        end else begin
          state_d = REPORT;
        end
      end

      REPORT: begin
        // Results are frozen here; start edges are deliberately ignored.
        if (meas_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Stage: FSM state and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      delay_q   <= '0;
      width_q   <= '0;
      tmr_q     <= '0;
      timeout_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
      sat_q     <= sat_d;
    end
  end

  assign meas_valid = (state_q == REPORT);
  assign busy       = (state_q != IDLE);
  assign delay_out  = delay_q;
  assign width_out  = width_q;
  assign timeout    = timeout_q;
  assign saturated  = sat_q;

endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor
//   Bench for pulse_monitor. dut_a uses CNT_W=16 with a short timeout so
//   abort cases are quick; dut_b uses CNT_W=4 for the saturation cases.
//   A vector table drives (delay, width) pulses, pushes the expected result
//   onto a scoreboard queue, and pops it when the selected DUT reports.
module tb_pulse_monitor;

  localparam int TO_A = 64;
  localparam int TO_B = 100;

  logic clk = 1'b0;
  logic reset;
  logic st, pulse, rdy, sel;

  logic        start_a, ready_a, valid_a, to_a, sat_a, busy_a;
  logic [15:0] delay_a, width_a;
  logic        start_b, ready_b, valid_b, to_b, sat_b, busy_b;
  logic [3:0]  delay_b, width_b;

  logic        v_sel, t_sel, s_sel, b_sel;
  logic [15:0] d_sel, w_sel;
  logic [34:0] act_vec;

  typedef struct {
    logic [15:0] delay;
    logic [15:0] width;
    logic        to;
    logic        sat;
  } exp_t;

  typedef struct {
    bit          sel;
    int          d;
    int          w;
    int          hold;
    logic [15:0] ed;
    logic [15:0] ew;
    logic        et;
    logic        es;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[9];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  assign start_a = st & ~sel;
  assign start_b = st & sel;
  assign ready_a = rdy & ~sel;
  assign ready_b = rdy & sel;

  always_comb begin
    if (sel) begin
      v_sel = valid_b; d_sel = {12'b0, delay_b}; w_sel = {12'b0, width_b};
      t_sel = to_b;    s_sel = sat_b;            b_sel = busy_b;
    end else begin
      v_sel = valid_a; d_sel = delay_a; w_sel = width_a;
      t_sel = to_a;    s_sel = sat_a;   b_sel = busy_a;
    end
    act_vec = {v_sel, d_sel, w_sel, t_sel, s_sel};
  end

  pulse_monitor #(.SYNC_STAGES(2), .CNT_W(16), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pulse_in(pulse),
    .meas_valid(valid_a), .meas_ready(ready_a), .delay_out(delay_a),
    .width_out(width_a), .timeout(to_a), .saturated(sat_a), .busy(busy_a)
  );

  pulse_monitor #(.SYNC_STAGES(2), .CNT_W(4), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pulse_in(pulse),
    .meas_valid(valid_b), .meas_ready(ready_b), .delay_out(delay_b),
    .width_out(width_b), .timeout(to_b), .saturated(sat_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Start rises sampled at edge N, pulse first sampled at N+d for w edges.
  task automatic send(input int d, input int w, input exp_t e);
    sb.push_back(e);
    for (int c = 0; c < d + w + 3; c++) begin
      st    = (c < 2);
      pulse = (w > 0) && (c >= d) && (c < d + w);
      tick();
    end
    st    = 1'b0;
    pulse = 1'b0;
  endtask

  // Wait for a result, hold it for 'hold' cycles (optionally poking start),
  // then accept it and check it leaves cleanly.
  task automatic collect(input int hold, input bit poke);
    exp_t        e;
    logic [34:0] exp_vec;
    int          n;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    n = 0;
    while (!v_sel && n < 400) begin
      tick();
      n++;
    end
    if (!v_sel) begin
      n_tests++; n_fail++;
      $display("FAIL result_wait: got no meas_valid in 400 cycles, expected a result");
      return;
    end
    exp_vec = {1'b1, e.delay, e.width, e.to, e.sat};
    chk("result", act_vec, exp_vec);
    for (int i = 0; i < hold; i++) begin
      st = poke && (i == 2 || i == 3);
      tick();
      chk("hold_stable", act_vec, exp_vec);
    end
    st  = 1'b0;
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    chk("valid_drop", {63'b0, v_sel}, 64'd0);
    chk("idle_after_ack", {63'b0, b_sel}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit   any_busy;

    tbl[0] = '{0, 5,  10, 0, 16'd5,  16'd10, 1'b0, 1'b0};
    tbl[1] = '{0, 1,  1,  2, 16'd1,  16'd1,  1'b0, 1'b0};
    tbl[2] = '{0, 12, 25, 1, 16'd12, 16'd25, 1'b0, 1'b0};
    tbl[3] = '{0, 63, 2,  0, 16'd63, 16'd2,  1'b0, 1'b0};
    tbl[4] = '{0, 2,  63, 0, 16'd2,  16'd63, 1'b0, 1'b0};
    tbl[5] = '{0, 10, 0,  0, 16'd64, 16'd0,  1'b1, 1'b0};
    tbl[6] = '{0, 4,  80, 0, 16'd4,  16'd64, 1'b1, 1'b0};
    tbl[7] = '{1, 2,  20, 3, 16'd2,  16'd15, 1'b0, 1'b1};
    tbl[8] = '{1, 3,  15, 0, 16'd3,  16'd15, 1'b0, 1'b0};

    reset = 1'b0; st = 1'b0; pulse = 1'b0; rdy = 1'b0; sel = 1'b0;
    repeat (3) tick();
    chk("reset_a", {valid_a, busy_a, to_a, sat_a, delay_a, width_a}, 64'd0);
    chk("reset_b", {valid_b, busy_b, to_b, sat_b, delay_b, width_b}, 64'd0);
    reset = 1'b1;
    repeat (4) tick();

    // pulse_in activity with no start must not start a measurement
    any_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse = (i < 3);
      tick();
      any_busy |= busy_a;
    end
    chk("idle_pulse_ignored", {63'b0, any_busy}, 64'd0);
    repeat (3) tick();

    for (int i = 0; i < 9; i++) begin
      sel = tbl[i].sel;
      e   = '{tbl[i].ed, tbl[i].ew, tbl[i].et, tbl[i].es};
      send(tbl[i].d, tbl[i].w, e);
      collect(tbl[i].hold, 1'b0);
      tick();
    end
    sel = 1'b0;

    // Result held 8 cycles; a start rise inside the window is ignored.
    send(3, 7, '{16'd3, 16'd7, 1'b0, 1'b0});
    collect(8, 1'b1);
    repeat (4) tick();
    chk("late_start_ignored", {63'b0, busy_a}, 64'd0);

    // Reset during MEASURE_HIGH clears everything without a handshake.
    for (int c = 0; c < 12; c++) begin
      st    = (c < 2);
      pulse = (c >= 4);
      tick();
    end
    chk("busy_before_reset", {63'b0, busy_a}, 64'd1);
    #2 reset = 1'b0;
    #1 chk("async_reset", {valid_a, busy_a, to_a, sat_a, delay_a, width_a}, 64'd0);
    pulse = 1'b0;
    st    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("idle_after_reset", {62'b0, busy_a, valid_a}, 64'd0);
    send(6, 4, '{16'd6, 16'd4, 1'b0, 1'b0});
    collect(0, 1'b0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flip-flop stages in the pulse_in synchronizer (legal 2-4).
REQ-002 Parameter CNT_W, default 16, width of the delay and width counters.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, maximum cycles waited for each pulse edge before abort.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; 0 forces reset state immediately, release is synchronous to clk.
REQ-006 start  input  1  synchronous trigger, same timing as the pulse_generator start input.
REQ-007 pulse_in  input  1  asynchronous pulse under measurement (pulse_generator pulse_out).
REQ-008 meas_valid  output  1  result held and available.
REQ-009 meas_ready  input  1  consumer accepts the result when meas_valid=1 and meas_ready=1 on the same edge.
REQ-010 delay_out  output  CNT_W  cycles from start rise to pulse_in rise.
REQ-011 width_out  output  CNT_W  cycles pulse_in held high.
REQ-012 timeout  output  1  result aborted: an edge was not seen within TIMEOUT_CYCLES.
REQ-013 saturated  output  1  at least one counter clipped at all-ones.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 pulse_in SHALL pass through SYNC_STAGES flip-flops; start SHALL pass through an equal-length register pipeline so both are aligned before edge detection.
REQ-016 A rising edge SHALL be detected as current sampled value 1 and previous sampled value 0, both taken after the pipeline.
REQ-017 FSM states: IDLE, WAIT_RISE, MEASURE_HIGH, REPORT.
REQ-018 IDLE: on aligned start rise -> WAIT_RISE; clear both counters; clear timeout and saturated.
REQ-019 WAIT_RISE: increment delay counter each cycle; on aligned pulse_in rise -> MEASURE_HIGH; if the counter reaches TIMEOUT_CYCLES -> REPORT with timeout=1.
REQ-020 MEASURE_HIGH: increment width counter each cycle pulse_in is sampled 1; on sampled 0 -> REPORT; if the counter reaches TIMEOUT_CYCLES -> REPORT with timeout=1.
REQ-021 Reporting rule: start first sampled high at edge N and pulse_in first sampled high at edge N+D SHALL give delay_out=D; pulse_in high for W sampled edges SHALL give width_out=W.
REQ-022 Counters SHALL saturate at 2^CNT_W-1 and SHALL set saturated=1; they SHALL NOT wrap.
REQ-023 REPORT: meas_valid=1; delay_out, width_out, timeout and saturated SHALL stay stable until the handshake; on handshake -> IDLE and meas_valid=0 on the next cycle.
REQ-024 start rises outside IDLE SHALL be ignored and SHALL NOT restart the measurement.
REQ-025 A pulse_in rise while in IDLE (no prior start) SHALL be ignored.
REQ-026 If start rise and pulse_in rise align on the same cycle in IDLE, the FSM SHALL go to WAIT_RISE; that pulse is not measured (D=0 is not representable).
REQ-027 If the handshake occurs on the same cycle as a new start rise, the start SHALL be lost; the consumer must hold start off until busy=0.

Reset
REQ-028 While reset=0: state=IDLE; meas_valid=0, busy=0, timeout=0, saturated=0, delay_out=0, width_out=0; synchronizer and start pipeline cleared to 0.
REQ-029 Reset asserted mid-measurement or during REPORT SHALL discard the result with no handshake.
REQ-030 After reset release, the first start rise SHALL be recognised no earlier than SYNC_STAGES+1 cycles later.

Verification
REQ-031 start rise at edge 20, pulse_in high edges 25-34 -> meas_valid with delay_out=5, width_out=10, timeout=0, saturated=0.
REQ-032 start rise, pulse_in held low -> after TIMEOUT_CYCLES: meas_valid=1, timeout=1, width_out=0.
REQ-033 CNT_W=4, pulse high 20 cycles -> width_out=15, saturated=1, no wrap.
REQ-034 meas_ready=0 for 8 cycles in REPORT -> outputs stable, meas_valid held; second start during that window ignored.
REQ-035 reset=0 during MEASURE_HIGH -> all outputs 0 asynchronously; a fresh start/pulse after release is measured correctly.
REQ-036 Back-to-back operation with the pulse_generator (start_delay_c, pulse_width_c) -> delay_out=start_delay_c, width_out=pulse_width_c.
